// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the data RAM arbiter.
// Latency: none, wiring only.
// Backpressure: requesters hold req/adr/wdata until their gnt pulse.
interface mem_port_arbiter_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 16
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_BITS-1:0] cpu_adr;
    logic [WIDTH-1:0]     cpu_wdata;
    logic                 cpu_gnt;
    logic                 cpu_rvalid;

    logic                 pin_req;
    logic [ADDR_BITS-1:0] pin_adr;
    logic [WIDTH-1:0]     pin_wdata;
    logic                 pin_gnt;

    logic                 vga_req;
    logic [ADDR_BITS-1:0] vga_adr;
    logic                 vga_gnt;
    logic                 vga_rvalid;

    logic [WIDTH-1:0]     rdata;

    logic                 mem_en;
    logic                 mem_write;
    logic                 mem_read;
    logic [ADDR_BITS-1:0] mem_adr;
    logic [WIDTH-1:0]     mem_wdata;
    logic [WIDTH-1:0]     mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  pin_req, pin_adr, pin_wdata,
        input  vga_req, vga_adr,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, pin_gnt, vga_gnt, vga_rvalid, rdata,
        output mem_en, mem_write, mem_read, mem_adr, mem_wdata
    );

    // Requesters plus RAM side.
    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output pin_req, pin_adr, pin_wdata,
        output vga_req, vga_adr,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, pin_gnt, vga_gnt, vga_rvalid, rdata,
        input  mem_en, mem_write, mem_read, mem_adr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port clocked RAM between CPU, player-input writer and display reader.
// Latency: gnt one cycle after req seen in IDLE, RAM access next edge, rvalid one edge later.
// Backpressure: losers keep req high; starvation counters let PIN/VGA override CPU.
module mem_port_arbiter #(
    parameter int WIDTH        = 16,
    parameter int ADDR_BITS    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;
    typedef enum logic [1:0] {OWN_CPU, OWN_PIN, OWN_VGA} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    owner_t     owner;
    logic [3:0] pin_starve;
    logic [3:0] vga_starve;
    logic       pick_cpu;
    logic       pick_pin;
    logic       pick_vga;
    logic       any_req;

    // Read data comes straight from the RAM's output register.
    assign bus.rdata = bus.mem_rdata;

    assign any_req = bus.cpu_req | bus.pin_req | bus.vga_req;

    // Winner selection: a saturated PIN, then a saturated VGA, then CPU > PIN > VGA.
    always_comb begin
        pick_cpu = 1'b0;
        pick_pin = 1'b0;
        pick_vga = 1'b0;
        if (bus.pin_req && pin_starve == LIMIT)      pick_pin = 1'b1;
        else if (bus.vga_req && vga_starve == LIMIT) pick_vga = 1'b1;
        else if (bus.cpu_req)                        pick_cpu = 1'b1;
        else if (bus.pin_req)                        pick_pin = 1'b1;
        else if (bus.vga_req)                        pick_vga = 1'b1;
    end

    // Access sequencer: arbitrate in IDLE, strobe RAM in ISSUE, return read data after RWAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            owner          <= OWN_CPU;
            pin_starve     <= '0;
            vga_starve     <= '0;
            bus.cpu_gnt    <= 1'b0;
            bus.pin_gnt    <= 1'b0;
            bus.vga_gnt    <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.vga_rvalid <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_adr    <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            // Grants and read strobes are single-cycle pulses.
            bus.cpu_gnt    <= 1'b0;
            bus.pin_gnt    <= 1'b0;
            bus.vga_gnt    <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.vga_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ISSUE;
                        bus.mem_en <= 1'b1;
                        if (pick_cpu) begin
                            owner         <= OWN_CPU;
                            bus.cpu_gnt   <= 1'b1;
                            bus.mem_write <= bus.cpu_we;
                            bus.mem_read  <= ~bus.cpu_we;
                            bus.mem_adr   <= bus.cpu_adr;
                            bus.mem_wdata <= bus.cpu_wdata;
                        end else if (pick_pin) begin
                            owner         <= OWN_PIN;
                            bus.pin_gnt   <= 1'b1;
                            bus.mem_write <= 1'b1;
                            bus.mem_read  <= 1'b0;
                            bus.mem_adr   <= bus.pin_adr;
                            bus.mem_wdata <= bus.pin_wdata;
                        end else begin
                            owner         <= OWN_VGA;
                            bus.vga_gnt   <= 1'b1;
                            bus.mem_write <= 1'b0;
                            bus.mem_read  <= 1'b1;
                            bus.mem_adr   <= bus.vga_adr;
                        end
                        // Count arbitrations lost while waiting; saturate at the limit.
                        if (!bus.pin_req || pick_pin)  pin_starve <= '0;
                        else if (pin_starve != LIMIT)  pin_starve <= pin_starve + 4'd1;
                        if (!bus.vga_req || pick_vga)  vga_starve <= '0;
                        else if (vga_starve != LIMIT)  vga_starve <= vga_starve + 4'd1;
                    end
                end
                ISSUE: begin
                    bus.mem_en    <= 1'b0;
                    bus.mem_write <= 1'b0;
                    bus.mem_read  <= 1'b0;
                    state         <= bus.mem_write ? IDLE : RWAIT;
                end
                RWAIT: begin
                    bus.cpu_rvalid <= (owner == OWN_CPU);
                    bus.vga_rvalid <= (owner == OWN_VGA);
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small clocked RAM model.
// Latency: checks grant/strobe timing cycle by cycle against hand-derived values.
// Backpressure: requesters hold req until gnt, then drop it unless held on purpose.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.WIDTH(16), .ADDR_BITS(16)) bus ();

    mem_port_arbiter #(.WIDTH(16), .ADDR_BITS(16), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, write on enabled edge, fixed power-up word at 0x21.
    logic [15:0] ram [256];
    logic [15:0] ram_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_q        <= '0;
            ram[8'h21]   <= 16'hBEEF;
        end else if (bus.mem_en) begin
            if (bus.mem_write) ram[bus.mem_adr[7:0]] <= bus.mem_wdata;
            if (bus.mem_read)  ram_q <= ram[bus.mem_adr[7:0]];
        end
    end
    assign bus.mem_rdata = ram_q;

    int n_tests = 0;
    int n_fail  = 0;

    int gq[$];
    int rv_cpu;
    int rv_vga;
    logic [15:0] cpu_data;
    logic [15:0] vga_data;
    logic [15:0] pin_adr_at;
    logic [15:0] pin_dat_at;
    logic bad_gnt;
    logic bad_rw;
    logic cpu_hold;

    int exp4[3] = '{1, 2, 3};
    int exp5[6] = '{1, 1, 1, 1, 2, 1};
    int exp6[7] = '{1, 1, 1, 1, 2, 3, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until n grants seen (plus a short tail for read strobes), logging grant order.
    task automatic collect(input int n, input int budget);
        int tail;
        int ng;
        tail = 0;
        gq.delete();
        rv_cpu = 0; rv_vga = 0;
        cpu_data = '0; vga_data = '0;
        pin_adr_at = '0; pin_dat_at = '0;
        bad_gnt = 1'b0; bad_rw = 1'b0;
        for (int c = 0; c < budget && tail < 5; c++) begin
            tick();
            ng = int'(bus.cpu_gnt) + int'(bus.pin_gnt) + int'(bus.vga_gnt);
            if (ng > 1) bad_gnt = 1'b1;
            if (bus.mem_write && bus.mem_read) bad_rw = 1'b1;
            if (bus.cpu_rvalid && bus.vga_rvalid) bad_gnt = 1'b1;
            if (bus.cpu_gnt) begin
                gq.push_back(1);
                if (!cpu_hold) bus.cpu_req = 1'b0;
            end
            if (bus.pin_gnt) begin
                gq.push_back(2);
                pin_adr_at = bus.mem_adr;
                pin_dat_at = bus.mem_wdata;
                bus.pin_req = 1'b0;
            end
            if (bus.vga_gnt) begin
                gq.push_back(3);
                bus.vga_req = 1'b0;
            end
            if (bus.cpu_rvalid) begin rv_cpu++; cpu_data = bus.rdata; end
            if (bus.vga_rvalid) begin rv_vga++; vga_data = bus.rdata; end
            if (gq.size() >= n) begin
                bus.cpu_req = 1'b0;
                tail++;
            end
        end
        bus.cpu_req = 1'b0;
        check("grant_count", gq.size(), n);
        check("gnt_onehot", bad_gnt, 1'b0);
        check("rw_exclusive", bad_rw, 1'b0);
    endtask

    function automatic int gq_at(input int i);
        return (i < gq.size()) ? gq[i] : 0;
    endfunction

    initial begin
        logic seen_rv;
        logic seen_en;
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        logic seen_rv;
        logic seen_en;
        rst = 1'b0;
        cpu_hold = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
        bus.pin_req = 1'b0; bus.pin_adr = '0; bus.pin_wdata = '0;
        bus.vga_req = 1'b0; bus.vga_adr = '0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // Reset during ISSUE of a CPU read at 0x0010.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 16'h0010;
        tick();
        check("rst_pre_gnt", bus.cpu_gnt, 1'b1);
        check("rst_pre_read", bus.mem_read, 1'b1);
        bus.cpu_req = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_gnt", bus.cpu_gnt, 1'b0);
        check("rst_en", bus.mem_en, 1'b0);
        check("rst_read", bus.mem_read, 1'b0);
        check("rst_write", bus.mem_write, 1'b0);
        check("rst_adr", bus.mem_adr, 16'h0000);
        check("rst_rdata", bus.rdata, 16'h0000);
        tick();
        rst = 1'b1;
        seen_rv = 1'b0; seen_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_rv |= bus.cpu_rvalid | bus.vga_rvalid;
            seen_en |= bus.mem_en;
        end
        check("post_rst_rvalid", seen_rv, 1'b0);
        check("idle_en", seen_en, 1'b0);

        // Single CPU read of 0x0021.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 16'h0021;
        tick();
        check("rd_gnt", bus.cpu_gnt, 1'b1);
        check("rd_en", bus.mem_en, 1'b1);
        check("rd_read", bus.mem_read, 1'b1);
        check("rd_write", bus.mem_write, 1'b0);
        check("rd_adr", bus.mem_adr, 16'h0021);
        bus.cpu_req = 1'b0;
        tick();
        check("rd_gnt_pulse", bus.cpu_gnt, 1'b0);
        check("rd_en_drop", bus.mem_en, 1'b0);
        check("rd_rvalid_early", bus.cpu_rvalid, 1'b0);
        tick();
        check("rd_rvalid", bus.cpu_rvalid, 1'b1);
        check("rd_data", bus.rdata, 16'hBEEF);
        check("rd_vga_rvalid", bus.vga_rvalid, 1'b0);
        tick();
        check("rd_rvalid_pulse", bus.cpu_rvalid, 1'b0);

        // CPU write 0x1234 to 0x002D, then read it back.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 16'h002D; bus.cpu_wdata = 16'h1234;
        tick();
        check("wr_gnt", bus.cpu_gnt, 1'b1);
        check("wr_write", bus.mem_write, 1'b1);
        check("wr_read", bus.mem_read, 1'b0);
        check("wr_adr", bus.mem_adr, 16'h002D);
        check("wr_wdata", bus.mem_wdata, 16'h1234);
        bus.cpu_req = 1'b0;
        tick();
        check("wr_write_drop", bus.mem_write, 1'b0);
        check("wr_en_drop", bus.mem_en, 1'b0);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
        tick();
        check("rb_gnt", bus.cpu_gnt, 1'b1);
        bus.cpu_req = 1'b0;
        tick();
        tick();
        check("rb_rvalid", bus.cpu_rvalid, 1'b1);
        check("rb_data", bus.rdata, 16'h1234);
        tick();

        // Simultaneous single requests: CPU reads 0x21, PIN writes 0x55 to 0x30, VGA reads 0x30.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 16'h0021;
        bus.pin_req = 1'b1; bus.pin_adr = 16'h0030; bus.pin_wdata = 16'h0055;
        bus.vga_req = 1'b1; bus.vga_adr = 16'h0030;
        collect(3, 40);
        for (int i = 0; i < 3; i++) check($sformatf("sim_order%0d", i), gq_at(i), exp4[i]);
        check("sim_cpu_rv", rv_cpu, 1);
        check("sim_cpu_data", cpu_data, 16'hBEEF);
        check("sim_vga_rv", rv_vga, 1);
        check("sim_vga_data", vga_data, 16'h0055);

        // Starvation: continuous CPU writes to 0x40, PIN holding a write of 3 to 0x20.
        cpu_hold = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 16'h0040; bus.cpu_wdata = 16'hAAAA;
        bus.pin_req = 1'b1; bus.pin_adr = 16'h0020; bus.pin_wdata = 16'h0003;
        collect(6, 60);
        for (int i = 0; i < 6; i++) check($sformatf("stv_order%0d", i), gq_at(i), exp5[i]);
        check("stv_pin_adr", pin_adr_at, 16'h0020);
        check("stv_pin_data", pin_dat_at, 16'h0003);
        check("stv_cpu_rv", rv_cpu, 0);

        // Both starved: PIN first, then VGA (reads 0x20 = 3), then CPU.
        bus.cpu_req = 1'b1;
        bus.pin_req = 1'b1; bus.pin_adr = 16'h0022; bus.pin_wdata = 16'h0007;
        bus.vga_req = 1'b1; bus.vga_adr = 16'h0020;
        collect(7, 60);
        for (int i = 0; i < 7; i++) check($sformatf("both_order%0d", i), gq_at(i), exp6[i]);
        check("both_vga_rv", rv_vga, 1);
        check("both_vga_data", vga_data, 16'h0003);
        check("both_pin_adr", pin_adr_at, 16'h0022);
        cpu_hold = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
